// File: rtl/decimating_sampler.sv
// Multi-channel decimator: every Neff enabled cycles it emits either the last
// sample (mode 0) or the window sum (mode 1) of each channel.
module decimating_sampler #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic [CNT_W-1:0]                   period,
    input  logic                               mode,
    input  logic [CHANNELS*WIDTH-1:0]          din,
    output logic [CHANNELS*(WIDTH+CNT_W)-1:0]  dout,
    output logic                               dout_valid,
    output logic [CNT_W-1:0]                   phase
);

    localparam int OW = WIDTH + CNT_W;

    logic [CNT_W-1:0] r_period_q;
    logic             r_mode_q;
    logic [CNT_W-1:0] r_phase;
    logic             r_valid;

    logic [CNT_W-1:0] w_last_phase;
    logic             w_win_end;

    // A zero period behaves as a one-cycle window.
    assign w_last_phase = (r_period_q == '0) ? '0 : r_period_q - CNT_W'(1);
    assign w_win_end    = en && (r_phase == w_last_phase);

    // Window parameters are only reloaded at a window boundary (or in reset),
    // so the window in progress never sees a period/mode change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= '0;
            r_valid    <= 1'b0;
            r_period_q <= period;
            r_mode_q   <= mode;
        end else begin
            r_valid <= w_win_end;
            if (en) begin
                if (w_win_end) begin
                    r_phase    <= '0;
                    r_period_q <= period;
                    r_mode_q   <= mode;
                end else begin
                    r_phase <= r_phase + CNT_W'(1);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] w_din;
            logic [OW-1:0]    w_din_ext;
            logic [OW-1:0]    w_sum;
            logic [OW-1:0]    r_acc;
            logic [OW-1:0]    r_dout;

            assign w_din     = din[gi*WIDTH +: WIDTH];
            assign w_din_ext = {{CNT_W{1'b0}}, w_din};
            assign w_sum     = r_acc + w_din_ext;

            // The accumulator only grows in mode 1; it is cleared at every
            // window end, so it is already zero whenever mode 0 takes over.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_acc  <= '0;
                    r_dout <= '0;
                end else if (en) begin
                    if (w_win_end) begin
                        r_dout <= r_mode_q ? w_sum : w_din_ext;
                        r_acc  <= '0;
                    end else if (r_mode_q) begin
                        r_acc <= w_sum;
                    end
                end
            end

            assign dout[gi*OW +: OW] = r_dout;
        end
    endgenerate

    assign dout_valid = r_valid;
    assign phase      = r_phase;

endmodule

// File: tb/tb_decimating_sampler.sv
// Randomized bench for decimating_sampler with a window-counting reference model.
module tb_decimating_sampler;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int OW = W + CW;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [CW-1:0]     period;
    logic              mode;
    logic [CH*W-1:0]   din;
    logic [CH*OW-1:0]  dout;
    logic              dout_valid;
    logic [CW-1:0]     phase;

    int total = 0;
    int bad   = 0;

    // Reference model: counts elapsed cycles of the current window and keeps
    // running sums as plain integers.
    int     m_len;
    int     m_cnt;
    bit     m_mode;
    longint m_sum[CH];
    longint exp_dout[CH];
    bit     exp_valid;

    decimating_sampler #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .period(period), .mode(mode),
        .din(din), .dout(dout), .dout_valid(dout_valid), .phase(phase)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int eff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic longint din_ch(input int c);
        return longint'(din[c*W +: W]);
    endfunction

    function automatic longint dout_ch(input int c);
        return longint'(dout[c*OW +: OW]);
    endfunction

    task automatic model_clock();
        if (reset) begin
            m_cnt = 0; m_len = eff(int'(period)); m_mode = mode; exp_valid = 0;
            for (int c = 0; c < CH; c++) begin m_sum[c] = 0; exp_dout[c] = 0; end
        end else if (!en) begin
            exp_valid = 0;
        end else begin
            m_cnt++;
            if (m_cnt == m_len) begin
                for (int c = 0; c < CH; c++) begin
                    exp_dout[c] = m_mode ? m_sum[c] + din_ch(c) : din_ch(c);
                    m_sum[c] = 0;
                end
                m_cnt = 0; exp_valid = 1;
                m_len = eff(int'(period)); m_mode = mode;
            end else begin
                exp_valid = 0;
                if (m_mode) for (int c = 0; c < CH; c++) m_sum[c] += din_ch(c);
            end
        end
    endtask

    // Advance one clock: update model with the inputs of this cycle, then
    // sample the DUT 1 time unit after the edge.
    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int p, input bit md);
        reset = 1; en = 1; period = CW'(p); mode = md; din = $urandom;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; en = 1; period = 8'd5; mode = 1; din = $urandom;
        step(); step();
        total++; if (phase !== 8'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", dout_valid); end
        total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
        reset = 0;
        $display("test_reset done");
    endtask

    task automatic test_sample();
        int exp_s[3] = '{4, 9, 14};
        int pulses = 0;
        do_reset(5, 0);
        for (int k = 0; k < 15; k++) begin
            din = $urandom; din[7:0] = 8'(k);
            step();
            total++;
            if (dout_valid !== ((k % 5) == 4)) begin
                bad++; $display("FAIL sample_valid k=%0d got=%0b want=%0b", k, dout_valid, (k % 5) == 4);
            end
            if (dout_valid === 1'b1 && pulses < 3) begin
                total++;
                if (dout_ch(0) !== longint'(exp_s[pulses])) begin
                    bad++; $display("FAIL sample_ch0 got=%0d want=%0d", dout_ch(0), exp_s[pulses]);
                end
                for (int c = 1; c < CH; c++) begin
                    total++;
                    if (dout_ch(c) !== exp_dout[c]) begin
                        bad++; $display("FAIL sample_ch%0d got=%0d want=%0d", c, dout_ch(c), exp_dout[c]);
                    end
                end
                pulses++;
            end
            $display("sample k=%0d din0=%0d valid=%0b dout0=%0d", k, k, dout_valid, dout_ch(0));
        end
        total++; if (pulses !== 3) begin bad++; $display("FAIL sample_pulses got=%0d want=3", pulses); end
    endtask

    task automatic test_accumulate();
        int pulses = 0;
        do_reset(4, 1);
        for (int k = 0; k < 4; k++) begin
            din = $urandom; din[7:0] = 8'd255; din[31:24] = 8'd1;
            step();
            if (dout_valid === 1'b1) pulses++;
            $display("acc k=%0d valid=%0b phase=%0d", k, dout_valid, phase);
        end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL acc_valid got=%0b want=1", dout_valid); end
        total++; if (dout_ch(0) !== 64'd1020) begin bad++; $display("FAIL acc_ch0 got=%0d want=1020", dout_ch(0)); end
        total++; if (dout_ch(3) !== 64'd4) begin bad++; $display("FAIL acc_ch3 got=%0d want=4", dout_ch(3)); end
        for (int c = 1; c < 3; c++) begin
            total++;
            if (dout_ch(c) !== exp_dout[c]) begin bad++; $display("FAIL acc_ch%0d got=%0d want=%0d", c, dout_ch(c), exp_dout[c]); end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL acc_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_enable_gating();
        bit en_seq[7]    = '{1, 0, 1, 0, 1, 0, 0};
        int exp_ph[7]    = '{1, 1, 2, 2, 0, 0, 0};
        bit exp_v[7]     = '{0, 0, 0, 0, 1, 0, 0};
        do_reset(3, 0);
        for (int k = 0; k < 7; k++) begin
            en = en_seq[k]; din = $urandom;
            step();
            total++;
            if (phase !== CW'(exp_ph[k]) || dout_valid !== exp_v[k]) begin
                bad++; $display("FAIL gate k=%0d phase got=%0d want=%0d valid got=%0b want=%0b",
                                k, phase, exp_ph[k], dout_valid, exp_v[k]);
            end
            $display("gate k=%0d en=%0b phase=%0d valid=%0b", k, en_seq[k], phase, dout_valid);
        end
        en = 1;
    endtask

    task automatic test_live_change();
        do_reset(5, 1);
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) period = 8'd2;
            din = $urandom;
            step();
            total++;
            if (dout_valid !== (k == 5 || k == 7 || k == 9)) begin
                bad++; $display("FAIL live_valid k=%0d got=%0b", k, dout_valid);
            end
            total++;
            if (phase !== CW'(m_cnt)) begin bad++; $display("FAIL live_phase k=%0d got=%0d want=%0d", k, phase, m_cnt); end
            if (dout_valid === 1'b1) begin
                total++;
                if (dout_ch(2) !== exp_dout[2]) begin bad++; $display("FAIL live_sum got=%0d want=%0d", dout_ch(2), exp_dout[2]); end
            end
            $display("live k=%0d phase=%0d valid=%0b", k, phase, dout_valid);
        end
    endtask

    task automatic test_period_edge();
        logic [CH*W-1:0] prev;
        for (int p = 0; p < 2; p++) begin
            for (int md = 0; md < 2; md++) begin
                do_reset(p, md[0]);
                for (int k = 0; k < 5; k++) begin
                    din = $urandom; prev = din;
                    step();
                    total++;
                    if (dout_valid !== 1'b1) begin bad++; $display("FAIL edge_valid p=%0d md=%0d got=0 want=1", p, md); end
                    for (int c = 0; c < CH; c++) begin
                        total++;
                        if (dout_ch(c) !== longint'(prev[c*W +: W])) begin
                            bad++; $display("FAIL edge_dout p=%0d md=%0d ch=%0d got=%0d want=%0d",
                                            p, md, c, dout_ch(c), prev[c*W +: W]);
                        end
                    end
                    $display("edge p=%0d md=%0d k=%0d valid=%0b", p, md, k, dout_valid);
                end
            end
        end
    endtask

    task automatic test_reset_mid_window();
        longint sums[CH];
        do_reset(8, 1);
        for (int k = 0; k < 5; k++) begin din = $urandom; step(); end
        total++; if (phase !== 8'd5) begin bad++; $display("FAIL mid_phase got=%0d want=5", phase); end
        reset = 1; din = $urandom;
        step();
        reset = 0;
        total++;
        if (dout_valid !== 1'b0 || dout !== '0 || phase !== 8'd0) begin
            bad++; $display("FAIL mid_reset valid=%0b dout=%h phase=%0d want 0/0/0", dout_valid, dout, phase);
        end
        for (int c = 0; c < CH; c++) sums[c] = 0;
        for (int k = 0; k < 8; k++) begin
            din = $urandom;
            for (int c = 0; c < CH; c++) sums[c] += longint'(din[c*W +: W]);
            step();
            total++;
            if (dout_valid !== (k == 7)) begin bad++; $display("FAIL mid_valid k=%0d got=%0b", k, dout_valid); end
        end
        for (int c = 0; c < CH; c++) begin
            total++;
            if (dout_ch(c) !== sums[c]) begin bad++; $display("FAIL mid_sum ch=%0d got=%0d want=%0d", c, dout_ch(c), sums[c]); end
        end
        $display("reset_mid done sum0=%0d", sums[0]);
    endtask

    task automatic test_random();
        do_reset(3, 0);
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 99) < 2);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) period = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) mode = $urandom;
            din = $urandom;
            step();
            total++;
            if (phase !== CW'(m_cnt) || dout_valid !== exp_valid) begin
                bad++; $display("FAIL rand_ctl k=%0d phase got=%0d want=%0d valid got=%0b want=%0b",
                                k, phase, m_cnt, dout_valid, exp_valid);
            end
            for (int c = 0; c < CH; c++) begin
                total++;
                if (dout_ch(c) !== exp_dout[c]) begin
                    bad++; $display("FAIL rand_dout k=%0d ch=%0d got=%0d want=%0d", k, c, dout_ch(c), exp_dout[c]);
                end
            end
            $display("rand k=%0d rst=%0b en=%0b per=%0d mode=%0b phase=%0d valid=%0b",
                     k, reset, en, period, mode, phase, dout_valid);
        end
        reset = 0;
    endtask

    initial begin
        reset = 1; en = 0; period = '0; mode = 0; din = '0;
        @(posedge clk); #1;
        test_reset();
        test_sample();
        test_accumulate();
        test_enable_gating();
        test_live_change();
        test_period_edge();
        test_reset_mid_window();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
